// File: rtl/decode_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage_if
// Description : Fetch-side inputs and decoded control outputs of decode_stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface decode_stage_if #(
    parameter int INSTR_W = 9,
    parameter int OPC_W   = 5,
    parameter int REG_W   = 4,
    parameter int CNT_W   = 32
);
    logic                     instr_valid;
    logic [INSTR_W-1:0]       instr_in;
    logic                     stall;
    logic                     flush;

    logic                     out_valid;
    logic [REG_W-1:0]         read_reg0;
    logic [REG_W-1:0]         read_reg1;
    logic [REG_W-1:0]         write_reg;
    logic                     write_en;
    logic                     move;
    logic                     immediate;
    logic                     branch;
    logic                     mem_read;
    logic                     mem_write;
    logic                     jump_sign;
    logic [3:0]               alu_op;
    logic [1:0]               reg_to_mem;
    logic [1:0]               quarter;
    logic [INSTR_W-OPC_W-1:0] imm_val;
    logic                     halt_signal;
    logic                     halted;
    logic [CNT_W-1:0]         dyn_count;

    modport slave (
        input  instr_valid, instr_in, stall, flush,
        output out_valid, read_reg0, read_reg1, write_reg, write_en, move,
               immediate, branch, mem_read, mem_write, jump_sign, alu_op,
               reg_to_mem, quarter, imm_val, halt_signal, halted, dyn_count
    );

    modport master (
        output instr_valid, instr_in, stall, flush,
        input  out_valid, read_reg0, read_reg1, write_reg, write_en, move,
               immediate, branch, mem_read, mem_write, jump_sign, alu_op,
               reg_to_mem, quarter, imm_val, halt_signal, halted, dyn_count
    );
endinterface
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage
// Description : Registered instruction decode with stall/flush, RUN/HALTED FSM
//               and a saturating accepted-instruction counter.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_stage #(
    parameter int INSTR_W = 9,
    parameter int OPC_W   = 5,
    parameter int REG_W   = 4,
    parameter int CNT_W   = 32
) (
    input  wire logic     clk,
    input  wire logic     rst,
    decode_stage_if.slave bus
);
    localparam int c_IMM_W = INSTR_W - OPC_W;

    localparam logic [1:0] c_ST_RUN       = 2'd0;
    localparam logic [1:0] c_ST_HALT_PEND = 2'd1;
    localparam logic [1:0] c_ST_HALTED    = 2'd2;

    localparam logic [REG_W-1:0] c_REG_ZERO = '0;
    localparam logic [REG_W-1:0] c_REG_ADR  = REG_W'(4);
    localparam logic [REG_W-1:0] c_REG_MATH = REG_W'(5);
    localparam logic [REG_W-1:0] c_REG_CNT  = REG_W'(7);

    typedef struct packed {
        logic [REG_W-1:0]   rr0;
        logic [REG_W-1:0]   rr1;
        logic [REG_W-1:0]   wr;
        logic               we;
        logic               mv;
        logic               imm;
        logic               br;
        logic               mr;
        logic               mw;
        logic               js;
        logic               hs;
        logic [3:0]         alu;
        logic [1:0]         rtm;
        logic [1:0]         q;
        logic [c_IMM_W-1:0] iv;
    } dec_t;

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic             w_run;
    logic             w_halted;
    logic             w_accept;
    logic [OPC_W-1:0] w_opc;
    logic [REG_W-1:0] w_r32;
    logic [REG_W-1:0] w_r10;
    dec_t             w_dec;
    dec_t             r_dec;
    logic             r_valid;
    logic [CNT_W-1:0] r_cnt;

    assign w_opc    = bus.instr_in[INSTR_W-1 -: OPC_W];
    assign w_r32    = {{(REG_W-2){1'b0}}, bus.instr_in[3:2]};
    assign w_r10    = {{(REG_W-2){1'b0}}, bus.instr_in[1:0]};
    assign w_accept = w_run & bus.instr_valid & ~bus.stall & ~bus.flush;

    // Opcode decode; every undefined opcode decodes exactly like halt.
    always_comb begin
        w_dec    = '0;
        w_dec.iv = bus.instr_in[c_IMM_W-1:0];
        case (w_opc)
            OPC_W'('h00): begin w_dec.rr0 = w_r32; w_dec.rr1 = c_REG_MATH; w_dec.wr = w_r10; w_dec.we = 1'b1; end
            OPC_W'('h01): begin w_dec.rr0 = w_r32; w_dec.rr1 = c_REG_MATH; w_dec.wr = w_r10; w_dec.we = 1'b1; w_dec.alu = 4'b0001; end
            OPC_W'('h02): begin w_dec.rr0 = w_r32; w_dec.wr = w_r10; w_dec.we = 1'b1; w_dec.mv = 1'b1; end
            OPC_W'('h03): begin w_dec.rr0 = w_r32; w_dec.wr = c_REG_ADR; w_dec.we = 1'b1; w_dec.mv = 1'b1; end
            OPC_W'('h04): begin w_dec.rr0 = c_REG_ADR; w_dec.wr = w_r10; w_dec.we = 1'b1; w_dec.mv = 1'b1; end
            OPC_W'('h05): begin w_dec.rr0 = c_REG_ZERO; w_dec.wr = c_REG_ADR; w_dec.we = 1'b1; w_dec.imm = 1'b1; w_dec.js = bus.instr_in[0]; end
            OPC_W'('h06): begin w_dec.wr = c_REG_MATH; w_dec.we = 1'b1; w_dec.imm = 1'b1; end
            OPC_W'('h07): begin w_dec.rr0 = c_REG_MATH; w_dec.wr = w_r10; w_dec.we = 1'b1; w_dec.mv = 1'b1; end
            OPC_W'('h08): begin w_dec.rr0 = w_r32; w_dec.wr = c_REG_MATH; w_dec.we = 1'b1; w_dec.mv = 1'b1; end
            OPC_W'('h09): begin w_dec.rr0 = c_REG_MATH; w_dec.q = bus.instr_in[3:2]; w_dec.wr = c_REG_ADR; w_dec.we = 1'b1; w_dec.mv = 1'b1; end
            OPC_W'('h0A): begin w_dec.rr0 = c_REG_MATH; w_dec.q = bus.instr_in[3:2]; w_dec.wr = w_r10; w_dec.we = 1'b1; w_dec.mv = 1'b1; end
            OPC_W'('h0B): begin w_dec.rr0 = w_r10; w_dec.q = bus.instr_in[3:2]; w_dec.wr = c_REG_CNT; w_dec.we = 1'b1; w_dec.mv = 1'b1; end
            OPC_W'('h0C): begin w_dec.rr0 = c_REG_CNT; w_dec.wr = w_r10; w_dec.we = 1'b1; w_dec.mv = 1'b1; end
            OPC_W'('h0D): begin w_dec.rr0 = w_r32; w_dec.wr = c_REG_CNT; w_dec.we = 1'b1; w_dec.mv = 1'b1; end
            OPC_W'('h0E): begin w_dec.rr0 = c_REG_ZERO; w_dec.wr = c_REG_CNT; w_dec.we = 1'b1; w_dec.imm = 1'b1; end
            OPC_W'('h0F): begin w_dec.br = 1'b1; w_dec.rr0 = w_r32; w_dec.rr1 = w_r10; w_dec.alu = 4'b0111; end
            OPC_W'('h10): begin w_dec.br = 1'b1; w_dec.rr0 = w_r32; w_dec.rr1 = w_r10; w_dec.alu = 4'b1000; end
            OPC_W'('h11): begin w_dec.br = 1'b1; w_dec.rr0 = w_r32; w_dec.rr1 = w_r10; w_dec.alu = 4'b0110; end
            OPC_W'('h12): begin w_dec.br = 1'b1; w_dec.rr0 = w_r32; w_dec.rr1 = w_r10; w_dec.alu = 4'b0101; end
            OPC_W'('h13): begin w_dec.br = 1'b1; w_dec.rr0 = w_r32; w_dec.rr1 = w_r10; w_dec.alu = 4'b0100; end
            OPC_W'('h14): begin w_dec.rr0 = w_r32; w_dec.wr = w_r10; w_dec.we = 1'b1; w_dec.alu = 4'b0010; end
            OPC_W'('h15): begin w_dec.rr0 = w_r32; w_dec.wr = w_r10; w_dec.we = 1'b1; w_dec.alu = 4'b0011; end
            OPC_W'('h16): begin w_dec.rr0 = w_r32; w_dec.rr1 = c_REG_ADR; w_dec.wr = w_r10; w_dec.we = 1'b1; w_dec.mr = 1'b1; end
            OPC_W'('h17): begin w_dec.rr0 = w_r32; w_dec.rr1 = c_REG_ADR; w_dec.mw = 1'b1; w_dec.rtm = bus.instr_in[1:0]; end
            OPC_W'('h18): begin w_dec.br = 1'b1; w_dec.alu = 4'b0111; end
            OPC_W'('h19): begin w_dec.rr0 = c_REG_ZERO; w_dec.wr = w_r10; w_dec.we = 1'b1; w_dec.imm = 1'b1; end
            default:      w_dec.hs = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // HALT_PEND is the one cycle in which the halting instruction is on the outputs.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_RUN:       if (w_accept && w_dec.hs) w_next_state = c_ST_HALT_PEND;
            c_ST_HALT_PEND: w_next_state = c_ST_HALTED;
            c_ST_HALTED:    w_next_state = c_ST_HALTED;
            default:        w_next_state = c_ST_RUN;
        endcase
    end

    always_comb begin
        w_run    = (r_state == c_ST_RUN);
        w_halted = (r_state == c_ST_HALTED);
    end

    // Leaving RUN or a flush clears the slot even under stall, so no strobe can linger.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dec   <= '0;
            r_valid <= 1'b0;
        end else if (!w_run || bus.flush) begin
            r_dec   <= '0;
            r_valid <= 1'b0;
        end else if (!bus.stall) begin
            if (bus.instr_valid) begin
                r_dec   <= w_dec;
                r_valid <= 1'b1;
            end else begin
                r_dec   <= '0;
                r_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_accept && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign bus.out_valid   = r_valid;
    assign bus.read_reg0   = r_dec.rr0;
    assign bus.read_reg1   = r_dec.rr1;
    assign bus.write_reg   = r_dec.wr;
    assign bus.write_en    = r_dec.we;
    assign bus.move        = r_dec.mv;
    assign bus.immediate   = r_dec.imm;
    assign bus.branch      = r_dec.br;
    assign bus.mem_read    = r_dec.mr;
    assign bus.mem_write   = r_dec.mw;
    assign bus.jump_sign   = r_dec.js;
    assign bus.alu_op      = r_dec.alu;
    assign bus.reg_to_mem  = r_dec.rtm;
    assign bus.quarter     = r_dec.q;
    assign bus.imm_val     = r_dec.iv;
    assign bus.halt_signal = r_dec.hs;
    assign bus.halted      = w_halted;
    assign bus.dyn_count   = r_cnt;
endmodule
`default_nettype wire

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, parametrised instruction-decode pipeline stage, the successor to the combinational control decoder.
- Sits between fetch and the register-file/ALU stage.
- Decodes one instruction per cycle into registered control signals, with a valid/stall/flush handshake.
- Adds a RUN/HALTED state machine and a saturating dynamic-instruction counter.

Parameters:
INSTR_W, 9, instruction width; opcode is instr_in[INSTR_W-1 -: OPC_W]; legal only if INSTR_W >= OPC_W+4
OPC_W, 5, opcode width; opcode values >= 5'h1B (zero-extended compare) are undefined
REG_W, 4, register-index output width; legal only if REG_W >= 3
CNT_W, 32, dynamic instruction counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
instr_valid  in  1  instr_in holds an instruction
instr_in  in  INSTR_W  instruction
stall  in  1  downstream stall; hold outputs, accept nothing
flush  in  1  squash the incoming instruction and the output slot
out_valid  out  1  decoded outputs are valid
read_reg0, read_reg1, write_reg  out  REG_W each  register indices (zero-extended fields)
write_en, move, immediate, branch, mem_read, mem_write, jump_sign  out  1 each  control strobes
alu_op  out  4  ALU operation
reg_to_mem  out  2  store source select
quarter  out  2  quarter select
imm_val  out  INSTR_W-OPC_W  operand bits, zero-extended
halt_signal  out  1  one-cycle pulse, valid with the halting instruction
halted  out  1  level, high in HALTED
dyn_count  out  CNT_W  accepted-instruction count

Behaviour:
- Reset (async): state RUN. All outputs 0, including out_valid, halted and dyn_count.
- Accept condition: state==RUN & instr_valid & !stall & !flush. On accept, the decode is registered and out_valid=1 on the next cycle (latency 1).
- Not accepted, no stall: out_valid=0. Side-effect strobes (write_en, mem_read, mem_write, branch, halt_signal) must be 0 whenever out_valid=0.
- Stall without flush: every output register holds.
- Flush: takes priority over stall. out_valid and all strobes clear next cycle; the counter does not increment.
- dyn_count: +1 per accept, saturates at all-ones.
- FSM:
  - RUN -> HALTED on accept of a halt opcode (1A) or an undefined opcode (1B-1F).
  - That instruction's output cycle shows out_valid=1, halt_signal=1, all other strobes 0.
  - HALTED: halted=1, halt_signal=0, out_valid=0, inputs ignored, counter frozen. Exit only via rst.
  - Halt accepted in the same cycle as a later flush: flush arrives one cycle late and has no effect on the halt already committed.
- Decode fields: r32=instr_in[3:2], r10=instr_in[1:0]. Special registers: ADR=4, MATH=5, CNT=7. Unlisted fields are 0.
  - 00 add: rr0=r32, rr1=5, wr=r10, we, alu=0000
  - 01 sub: as add, alu=0001
  - 02 mv: rr0=r32, wr=r10, we, move
  - 03 mvToAdr: rr0=r32, wr=4, we, move
  - 04 mvAdr: rr0=4, wr=r10, we, move
  - 05 rsAdr: rr0=0, wr=4, we, imm, jump_sign=instr_in[0]
  - 06 seti: imm_val=operand, wr=5, we, imm
  - 07 mvMath: rr0=5, wr=r10, we, move
  - 08 mvToMath: rr0=r32, wr=5, we, move
  - 09 mathToAdr: rr0=5, quarter=r32, wr=4, we, move
  - 0A setReg: rr0=5, quarter=r32, wr=r10, we, move
  - 0B setCnt: rr0=r10, quarter=r32, wr=7, we, move
  - 0C mvCnt: rr0=7, wr=r10, we, move
  - 0D mvToCnt: rr0=r32, wr=7, we, move
  - 0E rsCnt: rr0=0, wr=7, we, imm
  - 0F-13 be/bne/bez/bltz/bgte: branch, rr0=r32, rr1=r10; alu=0111/1000/0110/0101/0100
  - 14 evu / 15 evl: rr0=r32, wr=r10, we; alu=0010 / 0011
  - 16 ld: rr0=r32, rr1=4, wr=r10, we, mem_read
  - 17 st: rr0=r32, rr1=4, mem_write, reg_to_mem=r10
  - 18 jump: branch, rr0=rr1=0, alu=0111
  - 19 zeroReg: rr0=0, wr=r10, we, imm
- imm_val carries the operand bits for every opcode; only consumers of seti use it.

Test Plan:
- Reset, then add 9'b00000_10_11 valid -> next cycle out_valid=1, rr0=2, rr1=5, wr=3, write_en=1, alu=0000, dyn_count=1.
- Back-to-back st 9'b10111_01_10 then bne 9'b10000_11_00 -> cycle 1: mem_write=1, reg_to_mem=2, rr1=4, write_en=0; cycle 2: branch=1, alu=1000, rr0=3, rr1=0.
- Stall held 3 cycles after a ld, new instruction presented -> outputs frozen at the ld decode, dyn_count unchanged; the new instruction is accepted the cycle after stall drops.
- Flush and stall asserted together with seti valid -> next cycle out_valid=0, all strobes 0, dyn_count unchanged.
- Opcode 5'h1C valid -> out_valid=1, halt_signal=1 for one cycle, then halted=1, out_valid=0; subsequent add ignored; rst mid-HALTED -> RUN, dyn_count=0.
- CNT_W=4, 20 accepted adds -> dyn_count saturates at 15.
